// File: rtl/viterbi_channel_sim.sv
// Channel error injector between a convolutional encoder and a Viterbi decoder.
// Flips masked symbol bits on a periodic, pseudo-random or burst schedule and keeps windowed error statistics.
module viterbi_channel_sim #(
    parameter int unsigned W     = 2,
    parameter int unsigned N     = 3,
    parameter int unsigned BURST = 2,
    parameter int unsigned WIN   = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic [1:0]                 mode_i,
    input  logic [W-1:0]               mask_i,
    input  logic                       valid_i,
    input  logic [W-1:0]               sym_i,
    output logic                       valid_o,
    output logic [W-1:0]               sym_o,
    output logic                       err_o,
    output logic [$clog2(WIN+1)-1:0]   sym_ct_o,
    output logic [15:0]                bad_bit_ct_o,
    output logic                       window_done_o
);

    localparam int unsigned P  = 1 << N;
    localparam int unsigned CW = $clog2(WIN + 1);
    localparam int unsigned PW = $clog2(W + 1);
    localparam int unsigned BW = 16;
    localparam int unsigned SW = BW + 1;
    localparam int unsigned LW = 16;

    localparam logic [N-1:0]  SC_LAST    = N'(P - 1);
    localparam logic [N-1:0]  SC_BURST   = N'(P - BURST);
    localparam logic [CW-1:0] SYM_CT_END = CW'(WIN);
    localparam logic [LW-1:0] LFSR_SEED  = 16'hACE1;

    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_RANDOM   = 2'b10;
    localparam logic [1:0] MODE_BURST    = 2'b11;

    logic          valid_q, valid_d;
    logic [W-1:0]  sym_q, sym_d;
    logic          err_q, err_d;
    logic [N-1:0]  sc_q, sc_d;
    logic [LW-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0] sym_ct_q, sym_ct_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          done_q, done_d;

    logic          inj;
    logic [W-1:0]  flip;
    logic [PW-1:0] flip_ct;
    logic [SW-1:0] bad_sum;
    logic [BW-1:0] bad_sat;
    logic          lfsr_fb;
    logic [CW-1:0] sym_ct_inc;

    // Injection decision uses the symbol position before this symbol advances it
    always_comb begin
        inj = 1'b0;
        case (mode_i)
            MODE_PERIODIC: inj = (sc_q == SC_LAST);
            MODE_RANDOM:   inj = (lfsr_q[N-1:0] == '0);
            MODE_BURST:    inj = (sc_q >= SC_BURST);
            default:       inj = 1'b0;
        endcase
        if (clr_i) begin
            inj = 1'b0;
        end
    end

    // Corrupted-bit count for this symbol, folded into a saturating total
    always_comb begin
        flip    = mask_i & {W{inj}};
        flip_ct = '0;
        for (int i = 0; i < W; i++) begin
            flip_ct = flip_ct + PW'(flip[i]);
        end
        bad_sum = SW'(bad_q) + SW'(flip_ct);
        bad_sat = bad_sum[BW] ? {BW{1'b1}} : bad_sum[BW-1:0];
    end

    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign sym_ct_inc = sym_ct_q + CW'(1);

    always_comb begin
        valid_d  = valid_i;
        sym_d    = sym_q;
        err_d    = err_q;
        sc_d     = sc_q;
        lfsr_d   = lfsr_q;
        sym_ct_d = sym_ct_q;
        bad_d    = bad_q;
        done_d   = done_q;

        if (valid_i) begin
            sym_d  = sym_i ^ flip;
            err_d  = inj;
            sc_d   = sc_q + N'(1);
            lfsr_d = {lfsr_fb, lfsr_q[LW-1:1]};
        end

        // Clear wins over counting; the LFSR keeps running
        if (clr_i) begin
            sc_d     = '0;
            sym_ct_d = '0;
            bad_d    = '0;
            done_d   = 1'b0;
        end else if (valid_i && !done_q) begin
            sym_ct_d = sym_ct_inc;
            bad_d    = bad_sat;
            done_d   = (sym_ct_inc == SYM_CT_END);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            sym_q    <= '0;
            err_q    <= 1'b0;
            sc_q     <= '0;
            lfsr_q   <= LFSR_SEED;
            sym_ct_q <= '0;
            bad_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            sym_q    <= sym_d;
            err_q    <= err_d;
            sc_q     <= sc_d;
            lfsr_q   <= lfsr_d;
            sym_ct_q <= sym_ct_d;
            bad_q    <= bad_d;
            done_q   <= done_d;
        end
    end

    assign valid_o       = valid_q;
    assign sym_o         = sym_q;
    assign err_o         = err_q;
    assign sym_ct_o      = sym_ct_q;
    assign bad_bit_ct_o  = bad_q;
    assign window_done_o = done_q;

endmodule

// File: tb/tb_viterbi_channel_sim.sv
// Bench for viterbi_channel_sim: directed scenarios with literal expectations plus a
// per-cycle comparison against a position/modulo based reference model.
module tb_viterbi_channel_sim;

    localparam int unsigned W     = 2;
    localparam int unsigned N     = 3;
    localparam int unsigned BURST = 2;
    localparam int unsigned WIN   = 256;
    localparam int unsigned P     = 1 << N;
    localparam int unsigned CW    = $clog2(WIN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr_i = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [W-1:0]  mask_i = '0;
    logic          valid_i = 1'b0;
    logic [W-1:0]  sym_i = '0;
    logic          valid_o;
    logic [W-1:0]  sym_o;
    logic          err_o;
    logic [CW-1:0] sym_ct_o;
    logic [15:0]   bad_bit_ct_o;
    logic          window_done_o;

    int checks = 0;
    int errors = 0;

    viterbi_channel_sim #(.W(W), .N(N), .BURST(BURST), .WIN(WIN)) dut (
        .clk           (clk),
        .rst           (rst),
        .clr_i         (clr_i),
        .mode_i        (mode_i),
        .mask_i        (mask_i),
        .valid_i       (valid_i),
        .sym_i         (sym_i),
        .valid_o       (valid_o),
        .sym_o         (sym_o),
        .err_o         (err_o),
        .sym_ct_o      (sym_ct_o),
        .bad_bit_ct_o  (bad_bit_ct_o),
        .window_done_o (window_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: symbol position since last clear, modulo the period
    logic        m_valid = 1'b0;
    logic [1:0]  m_sym   = '0;
    logic        m_err   = 1'b0;
    logic [15:0] m_lfsr  = 16'hACE1;
    int          m_nsym  = 0;
    int          m_sct   = 0;
    int          m_bad   = 0;
    logic        m_done  = 1'b0;

    function automatic logic m_inj(input logic clr, input logic [1:0] md, input int nsym,
                                   input logic [15:0] lf);
        if (clr) return 1'b0;
        case (md)
            2'b01:   return (nsym % P) == (P - 1);
            2'b10:   return (int'(lf) % P) == 0;
            2'b11:   return (nsym % P) >= (P - BURST);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int v;
        int b;
        v = int'(s);
        b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (b << 15));
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_sym   <= '0;
            m_err   <= 1'b0;
            m_lfsr  <= 16'hACE1;
            m_nsym  <= 0;
            m_sct   <= 0;
            m_bad   <= 0;
            m_done  <= 1'b0;
        end else begin
            m_valid <= valid_i;
            if (valid_i) begin
                m_sym  <= m_inj(clr_i, mode_i, m_nsym, m_lfsr) ? (sym_i ^ mask_i) : sym_i;
                m_err  <= m_inj(clr_i, mode_i, m_nsym, m_lfsr);
                m_lfsr <= lfsr_step(m_lfsr);
            end
            if (clr_i) begin
                m_nsym <= 0;
                m_sct  <= 0;
                m_bad  <= 0;
                m_done <= 1'b0;
            end else if (valid_i) begin
                m_nsym <= m_nsym + 1;
                if (!m_done) begin
                    m_sct  <= m_sct + 1;
                    m_bad  <= sat16(m_bad + (m_inj(1'b0, mode_i, m_nsym, m_lfsr) ?
                                             $countones(mask_i) : 0));
                    m_done <= (m_sct + 1 == WIN);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_valid", 32'(valid_o), 32'(m_valid));
        chk("cmp_sym", 32'(sym_o), 32'(m_sym));
        chk("cmp_err", 32'(err_o), 32'(m_err));
        chk("cmp_sym_ct", 32'(sym_ct_o), 32'(m_sct));
        chk("cmp_bad", 32'(bad_bit_ct_o), 32'(m_bad));
        chk("cmp_done", 32'(window_done_o), 32'(m_done));
    end

    // Apply inputs at a falling edge and return at the next falling edge
    task automatic step(input logic v, input logic [1:0] s, input logic c);
        valid_i = v;
        sym_i   = s;
        clr_i   = c;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_valid"}, 32'(valid_o), 32'd0);
        chk({nm, "_sym"}, 32'(sym_o), 32'd0);
        chk({nm, "_err"}, 32'(err_o), 32'd0);
        chk({nm, "_sym_ct"}, 32'(sym_ct_o), 32'd0);
        chk({nm, "_bad"}, 32'(bad_bit_ct_o), 32'd0);
        chk({nm, "_done"}, 32'(window_done_o), 32'd0);
    endtask

    task automatic reset_pulse(input string nm);
        #2 rst = 1'b0;
        #1 check_all_zero(nm);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic rec [1:100];

    initial begin
        int nv;
        logic v;
        logic [1:0] s;

        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Periodic: flips on symbols 8 and 16
        mode_i = 2'b01;
        mask_i = 2'b10;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 2'b00, 1'b0);
            chk("periodic_err", 32'(err_o), 32'(k == 8 || k == 16));
            chk("periodic_sym", 32'(sym_o), (k % 8 == 0) ? 32'd2 : 32'd0);
        end
        chk("periodic_bad", 32'(bad_bit_ct_o), 32'd2);
        chk("periodic_sym_ct", 32'(sym_ct_o), 32'd16);

        // Clear with a valid symbol: forwarded clean, not counted
        step(1'b1, 2'b01, 1'b1);
        chk("clr_err", 32'(err_o), 32'd0);
        chk("clr_sym", 32'(sym_o), 32'd1);
        chk("clr_sym_ct", 32'(sym_ct_o), 32'd0);
        chk("clr_bad", 32'(bad_bit_ct_o), 32'd0);

        // Burst of 2: flips on 7, 8, 15, 16
        mode_i = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 2'b00, 1'b0);
            chk("burst_err", 32'(err_o), 32'(k % 8 == 7 || k % 8 == 0));
        end
        chk("burst_bad", 32'(bad_bit_ct_o), 32'd4);

        // Gapped valid: injection every 8th valid symbol, not every 8th cycle
        step(1'b0, 2'b00, 1'b1);
        mode_i = 2'b01;
        nv = 0;
        for (int c = 0; c < 32; c++) begin
            v = (c % 2 == 0);
            step(v, 2'b00, 1'b0);
            chk("gap_valid", 32'(valid_o), 32'(v));
            if (v) begin
                nv++;
                chk("gap_err", 32'(err_o), 32'(nv % 8 == 0));
            end
        end
        chk("gap_sym_ct", 32'(sym_ct_o), 32'd16);
        chk("gap_bad", 32'(bad_bit_ct_o), 32'd2);

        // Pass-through
        step(1'b0, 2'b00, 1'b1);
        mode_i = 2'b00;
        mask_i = 2'b11;
        for (int k = 0; k < 8; k++) begin
            s = 2'(k * 3 + 1);
            step(1'b1, s, 1'b0);
            chk("pass_sym", 32'(sym_o), 32'(s));
            chk("pass_err", 32'(err_o), 32'd0);
        end
        chk("pass_bad", 32'(bad_bit_ct_o), 32'd0);
        chk("pass_sym_ct", 32'(sym_ct_o), 32'd8);

        // Full window, then frozen counters while injection continues
        step(1'b0, 2'b00, 1'b1);
        mode_i = 2'b01;
        mask_i = 2'b11;
        for (int k = 1; k <= 256; k++) begin
            step(1'b1, 2'(k), 1'b0);
            if (k == 255) chk("win_done_early", 32'(window_done_o), 32'd0);
        end
        chk("win_done", 32'(window_done_o), 32'd1);
        chk("win_sym_ct", 32'(sym_ct_o), 32'd256);
        chk("win_bad", 32'(bad_bit_ct_o), 32'd64);
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 2'(k), 1'b0);
        end
        chk("win_frozen_err", 32'(err_o), 32'd1);
        chk("win_frozen_sym_ct", 32'(sym_ct_o), 32'd256);
        chk("win_frozen_bad", 32'(bad_bit_ct_o), 32'd64);
        chk("win_frozen_done", 32'(window_done_o), 32'd1);

        // Random mode: pattern after a reset must repeat after the next reset
        mode_i  = 2'b10;
        mask_i  = 2'b01;
        valid_i = 1'b0;
        reset_pulse("rst_a");
        for (int k = 1; k <= 100; k++) begin
            step(1'b1, 2'b00, 1'b0);
            rec[k] = m_err;
            if (k == 1) chk("rand_pin1", 32'(err_o), 32'd0);
            if (k == 2) chk("rand_pin2", 32'(err_o), 32'd1);
            if (k == 3) chk("rand_pin3", 32'(err_o), 32'd1);
            if (k == 4) chk("rand_pin4", 32'(err_o), 32'd0);
        end
        reset_pulse("rst_mid");
        for (int k = 1; k <= 100; k++) begin
            step(1'b1, 2'b00, 1'b0);
            chk("rand_replay", 32'(err_o), 32'(rec[k]));
        end
        chk("rand_sym_ct", 32'(sym_ct_o), 32'd100);
        valid_i = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_channel_sim.md
VITERBI_CHANNEL_SIM -- requirements
Module: viterbi_channel_sim

Interface
REQ-001 Parameter W, default 2: code symbol width in bits.
REQ-002 Parameter N, default 3: injection period exponent; period P = 2^N valid symbols.
REQ-003 Parameter BURST, default 2: burst length in symbols, 1 <= BURST <= P.
REQ-004 Parameter WIN, default 256: statistics window length in valid symbols.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-low.
REQ-007 clr_i  input  1  synchronous clear of symbol counter and statistics.
REQ-008 mode_i  input  2  00 pass-through, 01 periodic, 10 random, 11 burst.
REQ-009 mask_i  input  W  bits XORed into a symbol when an injection occurs.
REQ-010 valid_i  input  1  sym_i is a valid encoder output this cycle.
REQ-011 sym_i  input  W  encoder symbol.
REQ-012 valid_o  output  1  sym_o is valid; feeds the decoder enable.
REQ-013 sym_o  output  W  symbol after error injection.
REQ-014 err_o  output  1  injection applied to the current sym_o.
REQ-015 sym_ct_o  output  $clog2(WIN+1)  valid symbols counted in the current window.
REQ-016 bad_bit_ct_o  output  16  corrupted bits counted in the current window.
REQ-017 window_done_o  output  1  window complete; sticky until clr_i or reset.

Function
REQ-018 The block SHALL register all outputs, with exactly 1-cycle latency from valid_i/sym_i to valid_o/sym_o/err_o.
REQ-019 valid_o SHALL equal valid_i delayed one cycle; sym_o and err_o SHALL hold their previous values when valid_i = 0.
REQ-020 Internal symbol counter sc (N bits, wrapping) SHALL advance only on cycles with valid_i = 1.
REQ-021 Injection condition inj SHALL be evaluated on the pre-increment value of sc.
REQ-022 Mode 00: inj = 0.
REQ-023 Mode 01: inj = 1 when sc == P-1.
REQ-024 Mode 10: inj = 1 when lfsr[N-1:0] == 0.
REQ-025 Mode 11: inj = 1 when sc >= P-BURST.
REQ-026 The LFSR SHALL be 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing only on valid_i = 1, in all modes.
REQ-027 On valid_i with inj = 1: sym_o = sym_i ^ mask_i and err_o = 1; otherwise sym_o = sym_i and err_o = 0.
REQ-028 Changes to mode_i and mask_i SHALL take effect on the next valid symbol, with no clear of sc or the LFSR.
REQ-029 While window_done_o = 0, each valid symbol SHALL increment sym_ct_o and add popcount(sym_o ^ sym_i) to bad_bit_ct_o, in the same cycle that sym_o updates.
REQ-030 bad_bit_ct_o SHALL saturate at 16'hFFFF.
REQ-031 window_done_o SHALL assert in the cycle sym_ct_o reaches WIN; thereafter both counters SHALL freeze while injection continues.
REQ-032 clr_i = 1 SHALL zero sc, sym_ct_o, bad_bit_ct_o and window_done_o; the LFSR is not affected.
REQ-033 A valid symbol arriving in the same cycle as clr_i SHALL be forwarded clean (err_o = 0) and SHALL NOT be counted; clr_i has priority.

Reset
REQ-034 On rst low, the block SHALL immediately set: valid_o = 0, sym_o = 0, err_o = 0, sc = 0, LFSR = 16'hACE1, sym_ct_o = 0, bad_bit_ct_o = 0, window_done_o = 0.
REQ-035 Reset asserted mid-window SHALL discard all partial statistics; counting restarts with the first valid symbol after release.

Verification
REQ-036 W=2, N=3, mode 01, mask 2'b10, 16 consecutive valid sym_i = 2'b00 -> sym_o = 2'b10 with err_o = 1 on symbols 8 and 16 only; bad_bit_ct_o = 2.
REQ-037 Same setup with mode 11 and BURST=2 -> flips on symbols 7, 8, 15 and 16; bad_bit_ct_o = 4.
REQ-038 Mode 01, mask 2'b11, WIN=256, continuous valid -> window_done_o rises with sym_ct_o = 256 and bad_bit_ct_o = 64; both counters then stay fixed over the next 32 symbols.
REQ-039 valid_i toggling 1/0 each cycle in mode 01 -> injection every 8th valid symbol, not every 8th cycle; valid_o is valid_i delayed one cycle.
REQ-040 Mode 00 -> sym_o equals sym_i delayed one cycle and bad_bit_ct_o stays 0; clr_i with valid_i = 1 -> that symbol is not counted, and sym_ct_o = 0 the next cycle.
REQ-041 rst pulsed low after 100 symbols in mode 10 -> all outputs zero immediately; the injection pattern after release matches the first 100 symbols exactly (LFSR reseeded).
